dmem_responder: RTL and testbench

Data-memory responder on the far side of the core's data bus. It accepts the single-cycle core's write strobe, address and write data, and returns read data combinationally in the same cycle. Behind the bus it holds a word-addressed RAM and a small memory-mapped register bank: GPIO out, synchronised GPIO in, a prescaled timer with compare interrupt, and status. It sits at the top level between the CPU core's memory port and the board I/O.

---
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO GPIO, synchronised GPIO input and optional timer.
// Define DMEM_TIMER_EN to build the MTIME/MTIMECMP/STATUS timer block and irq_o logic.
module dmem_responder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAM_AW    = 10,
    parameter int unsigned GPIO_W    = 8,
    parameter int unsigned PRESCALE  = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_we_i,
    input  logic [WIDTH-1:0]  mem_addr_i,
    input  logic [WIDTH-1:0]  mem_data_i,
    output logic [WIDTH-1:0]  mem_data_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              irq_o
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam logic [2:0]  OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0]  OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0]  OFF_MTIME    = 3'd2;
    localparam logic [2:0]  OFF_MTIMECMP = 3'd3;
    localparam logic [2:0]  OFF_STATUS   = 3'd4;

    logic              w_sel_mmio;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [2:0]        w_off;
    logic              w_wr;
    logic              w_ram_we;
    logic              w_mmio_we;
    logic              w_unused;

    // Writes are suppressed while reset is held so a mid-write reset leaves RAM intact.
    assign w_sel_mmio = mem_addr_i[WIDTH-1];
    assign w_ram_idx  = mem_addr_i[RAM_AW+1:2];
    assign w_off      = mem_addr_i[4:2];
    assign w_wr       = mem_we_i & rst_i;
    assign w_ram_we   = w_wr & ~w_sel_mmio;
    assign w_mmio_we  = w_wr & w_sel_mmio;
    assign w_unused   = ^mem_addr_i;

    logic [WIDTH-1:0] r_ram [RAM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= mem_data_i;
        end
    end

    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_gpio_s1;
    logic [GPIO_W-1:0] r_gpio_s2;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gpio_out <= '0;
            r_gpio_s1  <= '0;
            r_gpio_s2  <= '0;
        end else begin
            r_gpio_s1 <= gpio_i;
            r_gpio_s2 <= r_gpio_s1;
            if (w_mmio_we && (w_off == OFF_GPIO_OUT)) begin
                r_gpio_out <= mem_data_i[GPIO_W-1:0];
            end
        end
    end

    assign gpio_o = r_gpio_out;

    logic [WIDTH-1:0] w_mtime_rd;
    logic [WIDTH-1:0] w_cmp_rd;
    logic [WIDTH-1:0] w_status_rd;

`ifdef DMEM_TIMER_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  r_presc;
    logic [WIDTH-1:0] r_mtime;
    logic [WIDTH-1:0] r_mtimecmp;
    logic             r_pend;
    logic             r_ie;

    logic             w_mtime_we;
    logic             w_cmp_we;
    logic             w_stat_we;
    logic             w_tick;
    logic             w_mtime_ld;
    logic [WIDTH-1:0] w_mtime_nxt;
    logic             w_hit;

    // PEND compares the value about to be loaded into MTIME, so a write landing on MTIMECMP also fires.
    assign w_mtime_we  = w_mmio_we && (w_off == OFF_MTIME);
    assign w_cmp_we    = w_mmio_we && (w_off == OFF_MTIMECMP);
    assign w_stat_we   = w_mmio_we && (w_off == OFF_STATUS);
    assign w_tick      = (r_presc == PS_W'(PRESCALE - 1));
    assign w_mtime_ld  = w_mtime_we | w_tick;
    assign w_mtime_nxt = w_mtime_we ? mem_data_i : (r_mtime + WIDTH'(1));
    assign w_hit       = w_mtime_ld && (w_mtime_nxt == r_mtimecmp);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_presc    <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_pend     <= 1'b0;
            r_ie       <= 1'b0;
        end else begin
            if (w_mtime_we || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PS_W'(1);
            end
            if (w_mtime_ld) begin
                r_mtime <= w_mtime_nxt;
            end
            if (w_cmp_we) begin
                r_mtimecmp <= mem_data_i;
            end
            if (w_hit) begin
                r_pend <= 1'b1;
            end else if (w_stat_we && mem_data_i[0]) begin
                r_pend <= 1'b0;
            end
            if (w_stat_we) begin
                r_ie <= mem_data_i[1];
            end
        end
    end

    assign w_mtime_rd  = r_mtime;
    assign w_cmp_rd    = r_mtimecmp;
    assign w_status_rd = {{(WIDTH-2){1'b0}}, r_ie, r_pend};
    assign irq_o       = r_pend & r_ie;
`else
    assign w_mtime_rd  = '0;
    assign w_cmp_rd    = '0;
    assign w_status_rd = '0;
    assign irq_o       = 1'b0;
`endif

    // Combinational read path; offsets 0x14-0x1C fall through to zero.
    always_comb begin
        mem_data_o = '0;
        if (!w_sel_mmio) begin
            mem_data_o = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                OFF_GPIO_OUT: mem_data_o = WIDTH'(r_gpio_out);
                OFF_GPIO_IN:  mem_data_o = WIDTH'(r_gpio_s2);
                OFF_MTIME:    mem_data_o = w_mtime_rd;
                OFF_MTIMECMP: mem_data_o = w_cmp_rd;
                OFF_STATUS:   mem_data_o = w_status_rd;
                default:      mem_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, timer/GPIO/reset sequences and a
// randomized run against a RAM/GPIO/MTIME reference model (PRESCALE=1 and PRESCALE=4 instances).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  gpio_i;
    logic [31:0] rdata1, rdata4;
    logic [7:0]  gpio_o1, gpio_o4;
    logic        irq1, irq4;

    int n_chk  = 0;
    int n_fail = 0;
    int n_since = 0;

    logic [31:0] ram_m [1024];
    bit          ram_v [1024];
    logic [7:0]  gpio_m;
    logic [31:0] mt_base;

    always #5 clk = ~clk;

    dmem_responder #(.PRESCALE(1)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .mem_we_i(we), .mem_addr_i(addr), .mem_data_i(wdata),
        .mem_data_o(rdata1), .gpio_i(gpio_i), .gpio_o(gpio_o1), .irq_o(irq1)
    );

    dmem_responder #(.PRESCALE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .mem_we_i(we), .mem_addr_i(addr), .mem_data_i(wdata),
        .mem_data_o(rdata4), .gpio_i(gpio_i), .gpio_o(gpio_o4), .irq_o(irq4)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        n_since++;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cyc();
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; addr = 32'h8000_0000; wdata = '0; gpio_i = '0;
        gpio_m = '0; mt_base = '0;
        for (int i = 0; i < 1024; i++) begin
            ram_v[i] = 1'b0;
            ram_m[i] = '0;
        end

        vt[0]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
        vt[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[3]  = '{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[4]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vt[5]  = '{1'b1, 32'h8000_0000, 32'h0000_00A5, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_00A5};
        vt[7]  = '{1'b0, 32'h8000_0003, 32'h0,         1'b1, 32'h0000_00A5};
        vt[8]  = '{1'b1, 32'h8000_0018, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vt[9]  = '{1'b0, 32'h8000_0018, 32'h0,         1'b1, 32'h0};
        vt[10] = '{1'b0, 32'h8000_0020, 32'h0,         1'b1, 32'h0000_00A5};

        // Reset state, observed without any clock edge
        #2;
        chk("rst_gpio_o", 32'(gpio_o1), 32'h0);
        chk("rst_irq", 32'(irq1), 32'h0);
        addr = 32'h8000_0008; #1;
`ifdef DMEM_TIMER_EN
        chk("rst_mtime", rdata1, 32'h0);
        addr = 32'h8000_000C; #1;
        chk("rst_mtimecmp", rdata1, 32'hFFFF_FFFF);
`else
        chk("rst_mtime_off", rdata1, 32'h0);
`endif
        addr = 32'h8000_0010; #1;
        chk("rst_status", rdata1, 32'h0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 11; i++) begin
            we = vt[i].we; addr = vt[i].addr; wdata = vt[i].wdata;
            #1;
            if (vt[i].chk) chk($sformatf("vec%0d", i), rdata1, vt[i].exp);
            cyc();
        end
        we = 1'b0;
        ram_m[4] = 32'hDEAD_BEEF; ram_v[4] = 1'b1;
        gpio_m = 8'hA5;
        chk("gpio_o_a5", 32'(gpio_o1), 32'h0000_00A5);

        // GPIO input synchroniser latency
        gpio_i = 8'h3C; addr = 32'h8000_0004; #1;
        chk("gpio_in_e0", rdata1, 32'h0);
        cyc(); #1;
        chk("gpio_in_e1", rdata1, 32'h0);
        cyc(); #1;
        chk("gpio_in_e2", rdata1, 32'h0000_003C);

`ifdef DMEM_TIMER_EN
        wr(32'h8000_0008, 32'd100);
        wr(32'h8000_000C, 32'd5);
        wr(32'h8000_0010, 32'h3);
        wr(32'h8000_0008, 32'd0);
        addr = 32'h8000_0008;
        for (int k = 1; k <= 6; k++) begin
            cyc(); #1;
            chk($sformatf("tmr_mtime%0d", k), rdata1, 32'(k));
            chk($sformatf("tmr_irq%0d", k), 32'(irq1), (k >= 5) ? 32'h1 : 32'h0);
        end
        wr(32'h8000_0010, 32'h3); #1;
        chk("w1c_irq", 32'(irq1), 32'h0);
        wr(32'h8000_0008, 32'd4);
        wr(32'h8000_0010, 32'h3); #1;
        chk("set_wins_irq", 32'(irq1), 32'h1);
        wr(32'h8000_0010, 32'h0); addr = 32'h8000_0010; #1;
        chk("ie0_irq", 32'(irq1), 32'h0);
        chk("ie0_status", rdata1, 32'h1);
        wr(32'h8000_0010, 32'h2); addr = 32'h8000_0010; #1;
        chk("ie1_irq", 32'(irq1), 32'h1);
        chk("ie1_status", rdata1, 32'h3);

        // MTIME wrap on the PRESCALE=4 instance
        wr(32'h8000_0008, 32'hFFFF_FFFE); addr = 32'h8000_0008; #1;
        chk("wrap_k0", rdata4, 32'hFFFF_FFFE);
        for (int k = 1; k <= 8; k++) begin
            cyc(); #1;
            chk($sformatf("wrap_k%0d", k), rdata4, 32'hFFFF_FFFE + 32'(k / 4));
        end
`else
        wr(32'h8000_0008, 32'h1234_5678); addr = 32'h8000_0008; #1;
        chk("notmr_mtime", rdata1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(); #1;
            chk($sformatf("notmr_irq%0d", k), 32'(irq1), 32'h0);
        end
        addr = 32'h8000_000C; #1;
        chk("notmr_cmp", rdata1, 32'h0);
`endif

        // Randomized run against the reference model
        we = 1'b1; addr = 32'h8000_0008; wdata = $urandom;
        mt_base = wdata; n_since = -1;
        cyc();
        we = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [9:0] idx;
            chk("rnd_gpio_o", 32'(gpio_o1), 32'(gpio_m));
            op = int'($urandom_range(0, 5));
            we = 1'b0; wdata = $urandom;
            case (op)
                0, 1: begin we = 1'b1; addr = $urandom & 32'h7FFF_FFFF; end
                2, 3: addr = $urandom & 32'h7FFF_FFFF;
                4: begin we = 1'($urandom_range(0, 1)); addr = ($urandom & 32'h7FFF_FFE3) | 32'h8000_0000; end
                default: begin we = 1'($urandom_range(0, 1)); addr = ($urandom & 32'h7FFF_FFE3) | 32'h8000_0008; end
            endcase
            #1;
            if (op <= 3) begin
                idx = addr[11:2];
                if (ram_v[idx]) begin
                    chk("rnd_ram", rdata1, ram_m[idx]);
                    chk("rnd_ram4", rdata4, ram_m[idx]);
                end
                if (we) begin
                    ram_m[idx] = wdata; ram_v[idx] = 1'b1;
                end
            end else if (op == 4) begin
                chk("rnd_gpio_rd", rdata1, 32'(gpio_m));
                if (we) gpio_m = wdata[7:0];
            end else begin
`ifdef DMEM_TIMER_EN
                chk("rnd_mtime1", rdata1, mt_base + 32'(n_since));
                chk("rnd_mtime4", rdata4, mt_base + 32'(n_since / 4));
                if (we) begin
                    mt_base = wdata; n_since = -1;
                end
`else
                chk("rnd_mtime_off", rdata1, 32'h0);
`endif
            end
            cyc();
        end
        we = 1'b0;

        // Asynchronous reset in the middle of a RAM write
        we = 1'b1; addr = 32'h0000_0010; wdata = 32'hBAD0_BAD0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gpio_o", 32'(gpio_o1), 32'h0);
        chk("mid_rst_gpio_o4", 32'(gpio_o4), 32'h0);
        chk("mid_rst_irq", 32'(irq1), 32'h0);
        chk("mid_rst_ram", rdata1, ram_m[4]);
        addr = 32'h8000_0008; #1;
        chk("mid_rst_mtime", rdata1, 32'h0);
        addr = 32'h8000_000C; #1;
`ifdef DMEM_TIMER_EN
        chk("mid_rst_cmp", rdata1, 32'hFFFF_FFFF);
`else
        chk("mid_rst_cmp", rdata1, 32'h0);
`endif
        addr = 32'h8000_0004; #1;
        chk("mid_rst_gpio_in", rdata1, 32'h0);
        addr = 32'h0000_0010;
        cyc(); cyc();
        rst_n = 1'b1; we = 1'b0;
        #1;
        chk("post_rst_ram", rdata1, ram_m[4]);
        chk("post_rst_ram4", rdata4, ram_m[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
